// File: rtl/sram_arb_pkg.sv
// Shared defaults and port index constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int DW_DEF         = 64;
  localparam int MW_DEF         = DW_DEF / 8;
  localparam int AW_DEF         = 14;
  localparam int STARVE_MAX_DEF = 4;

  // Port indices into the grant / pending vectors.
  localparam int PORT_CMP = 0;
  localparam int PORT_LD  = 1;

  typedef logic [3:0] starve_t;

endpackage

// File: rtl/sram_arb2.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Port 0 (compute) has fixed priority; port 1 (loader) is promoted after
// STARVE_MAX consecutive losses. Reads return one cycle after accept.
//
// Handshake: a request transfers on a rising edge where req_valid_x and
// req_ready_x are both 1; req_ready_x is the combinational grant and never
// depends on anything but the current valids and the starvation count.
// Requesters keep every request field stable while valid && !ready.
// Responses (rsp_valid_x) have no backpressure.
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int MW         = MW_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_0,
  output logic          req_ready_0,
  input  logic          req_we_0,
  input  logic [MW-1:0] req_wem_0,
  input  logic [AW-1:0] req_addr_0,
  input  logic [DW-1:0] req_wdata_0,
  output logic          rsp_valid_0,
  output logic [DW-1:0] rsp_rdata_0,
  input  logic          req_valid_1,
  output logic          req_ready_1,
  input  logic          req_we_1,
  input  logic [MW-1:0] req_wem_1,
  input  logic [AW-1:0] req_addr_1,
  input  logic [DW-1:0] req_wdata_1,
  output logic          rsp_valid_1,
  output logic [DW-1:0] rsp_rdata_1,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam starve_t STARVE_MAX_C = starve_t'(STARVE_MAX);

  logic [1:0]    gnt;
  logic          force1;
  starve_t       starve_cnt_q, starve_cnt_d;
  logic [1:0]    rd_pend_q, rd_pend_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  // Grant: port 1 wins when forced or uncontested, else port 0; none in reset.
  always_comb begin
    gnt    = 2'b00;
    force1 = (starve_cnt_q == STARVE_MAX_C);
    if (!rst) begin
      if (req_valid_1 && (force1 || !req_valid_0)) begin
        gnt[PORT_LD] = 1'b1;
      end else if (req_valid_0) begin
        gnt[PORT_CMP] = 1'b1;
      end
    end
  end

  assign req_ready_0 = gnt[PORT_CMP];
  assign req_ready_1 = gnt[PORT_LD];

  // SRAM drive: mux the winner; with no grant, address and data hold.
  always_comb begin
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_wem  = '0;
    sram_addr = addr_q;
    sram_din  = din_q;
    if (rst) begin
      sram_addr = '0;
      sram_din  = '0;
    end else if (gnt[PORT_LD]) begin
      sram_cs   = 1'b1;
      sram_we   = req_we_1;
      sram_wem  = req_wem_1;
      sram_addr = req_addr_1;
      sram_din  = req_wdata_1;
    end else if (gnt[PORT_CMP]) begin
      sram_cs   = 1'b1;
      sram_we   = req_we_0;
      sram_wem  = req_wem_0;
      sram_addr = req_addr_0;
      sram_din  = req_wdata_0;
    end
  end

  // Next-state for the starvation counter and the read-pending flags.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt[PORT_LD]) begin
      starve_cnt_d = '0;
    end else if (req_valid_1 && gnt[PORT_CMP] && (starve_cnt_q != STARVE_MAX_C)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    rd_pend_d[PORT_CMP] = gnt[PORT_CMP] && !req_we_0;
    rd_pend_d[PORT_LD]  = gnt[PORT_LD]  && !req_we_1;
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= '0;
      addr_q       <= '0;
      din_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      if (sram_cs) begin
        addr_q <= sram_addr;
        din_q  <= sram_din;
      end
    end
  end

  // Read return: SRAM output is steered to the port whose read is pending.
  assign rsp_valid_0 = rd_pend_q[PORT_CMP] && !rst;
  assign rsp_valid_1 = rd_pend_q[PORT_LD]  && !rst;
  assign rsp_rdata_0 = rsp_valid_0 ? sram_dout : '0;
  assign rsp_rdata_1 = rsp_valid_1 ? sram_dout : '0;

endmodule

// File: tb/tb_sram_arb2.sv
// Directed bench for sram_arb2 with a write-first single-port SRAM model.
module tb_sram_arb2;

  localparam logic [63:0] C = 64'hC0DE_0000_0000_0000;

  logic        clk, rst;
  logic        req_valid_0, req_ready_0, req_we_0;
  logic [7:0]  req_wem_0;
  logic [13:0] req_addr_0;
  logic [63:0] req_wdata_0;
  logic        rsp_valid_0;
  logic [63:0] rsp_rdata_0;
  logic        req_valid_1, req_ready_1, req_we_1;
  logic [7:0]  req_wem_1;
  logic [13:0] req_addr_1;
  logic [63:0] req_wdata_1;
  logic        rsp_valid_1;
  logic [63:0] rsp_rdata_1;
  logic        sram_cs, sram_we;
  logic [7:0]  sram_wem;
  logic [13:0] sram_addr;
  logic [63:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  sram_arb2 #(.DW(64), .MW(8), .AW(14), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_wem_0(req_wem_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_wem_1(req_wem_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-first synchronous SRAM model (256 words are enough for the test)
  logic [63:0] mem [256];
  initial begin
    logic [63:0] w;
    for (int k = 0; k < 256; k++) mem[k] = C | 64'(k);
    sram_dout = '0;
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        w = mem[sram_addr[7:0]];
        if (sram_we) begin
          for (int b = 0; b < 8; b++)
            if (sram_wem[b]) w[8*b +: 8] = sram_din[8*b +: 8];
          mem[sram_addr[7:0]] = w;
        end
        sram_dout <= w;
      end
    end
  end

  typedef struct {
    logic v0; logic we0; logic [7:0] wem0; logic [13:0] a0; logic [63:0] d0;
    logic v1; logic we1; logic [7:0] wem1; logic [13:0] a1; logic [63:0] d1;
    logic r0; logic r1; logic cs; logic we; logic [7:0] wem;
    logic [13:0] addr; logic [63:0] din;
    logic rv0; logic [63:0] rd0; logic rv1; logic [63:0] rd1;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic [7:0] wem0, input logic [13:0] a0, input logic [63:0] d0,
    input logic v1, input logic we1, input logic [7:0] wem1, input logic [13:0] a1, input logic [63:0] d1,
    input logic r0, input logic r1, input logic cs, input logic we, input logic [7:0] wem,
    input logic [13:0] addr, input logic [63:0] din,
    input logic rv0, input logic [63:0] rd0, input logic rv1, input logic [63:0] rd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.wem0 = wem0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.wem1 = wem1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.cs = cs; v.we = we; v.wem = wem; v.addr = addr; v.din = din;
    v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input vec_t v);
    req_valid_0 = v.v0; req_we_0 = v.we0; req_wem_0 = v.wem0; req_addr_0 = v.a0; req_wdata_0 = v.d0;
    req_valid_1 = v.v1; req_we_1 = v.we1; req_wem_1 = v.wem1; req_addr_1 = v.a1; req_wdata_1 = v.d1;
  endtask

  task automatic idle_all();
    req_valid_0 = 0; req_we_0 = 0; req_wem_0 = '0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 0; req_we_1 = 0; req_wem_1 = '0; req_addr_1 = '0; req_wdata_1 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready0"}, 64'(req_ready_0), 64'd0);
    chk({tag, " ready1"}, 64'(req_ready_1), 64'd0);
    chk({tag, " rsp_valid0"}, 64'(rsp_valid_0), 64'd0);
    chk({tag, " rsp_valid1"}, 64'(rsp_valid_1), 64'd0);
    chk({tag, " rsp_rdata0"}, rsp_rdata_0, 64'd0);
    chk({tag, " rsp_rdata1"}, rsp_rdata_1, 64'd0);
    chk({tag, " cs"}, 64'(sram_cs), 64'd0);
    chk({tag, " we"}, 64'(sram_we), 64'd0);
    chk({tag, " wem"}, 64'(sram_wem), 64'd0);
    chk({tag, " addr"}, 64'(sram_addr), 64'd0);
    chk({tag, " din"}, sram_din, 64'd0);
  endtask

  initial begin
    int p1_acc;
    string t;
    rst = 1'b1;
    idle_all();

    // Vector table: one row per cycle, responses are from the previous row.
    //             v0 we0 wem0  a0     d0                       v1 we1 wem1  a1   d1                       r0 r1 cs we wem   addr   din                      rv0 rd0                      rv1 rd1
    vecs[0]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    0, 0, 8'h00, 14'h0, 64'h0,                  0, 0, 0, 0, 8'h00, 14'h0,  64'h0,                   0, 64'h0,                    0, 64'h0);
    vecs[1]  = mk(1, 1, 8'hFF, 14'h10, 64'hDEADBEEF_01234567,  0, 0, 8'h00, 14'h0, 64'h0,                  1, 0, 1, 1, 8'hFF, 14'h10, 64'hDEADBEEF_01234567,   0, 64'h0,                    0, 64'h0);
    vecs[2]  = mk(1, 0, 8'h00, 14'h10, 64'h0,                   0, 0, 8'h00, 14'h0, 64'h0,                  1, 0, 1, 0, 8'h00, 14'h10, 64'h0,                   0, 64'h0,                    0, 64'h0);
    vecs[3]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    0, 0, 8'h00, 14'h0, 64'h0,                  0, 0, 0, 0, 8'h00, 14'h10, 64'h0,                   1, 64'hDEADBEEF_01234567,    0, 64'h0);
    vecs[4]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 1, 8'hFF, 14'h5, 64'hFFFFFFFF_FFFFFFFF,  0, 1, 1, 1, 8'hFF, 14'h5,  64'hFFFFFFFF_FFFFFFFF,   0, 64'h0,                    0, 64'h0);
    vecs[5]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 1, 8'h01, 14'h5, 64'h0,                  0, 1, 1, 1, 8'h01, 14'h5,  64'h0,                   0, 64'h0,                    0, 64'h0);
    vecs[6]  = mk(1, 0, 8'h00, 14'h5, 64'h0,                    0, 0, 8'h00, 14'h0, 64'h0,                  1, 0, 1, 0, 8'h00, 14'h5,  64'h0,                   0, 64'h0,                    0, 64'h0);
    vecs[7]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 0, 8'h00, 14'h1, 64'h0,                  0, 1, 1, 0, 8'h00, 14'h1,  64'h0,                   1, 64'hFFFFFFFF_FFFFFF00,    0, 64'h0);
    vecs[8]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 0, 8'h00, 14'h2, 64'h0,                  0, 1, 1, 0, 8'h00, 14'h2,  64'h0,                   0, 64'h0,                    1, C | 64'h1);
    vecs[9]  = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 0, 8'h00, 14'h3, 64'h0,                  0, 1, 1, 0, 8'h00, 14'h3,  64'h0,                   0, 64'h0,                    1, C | 64'h2);
    // Contention: both valid, grant 0,0,0,0,1 repeating.
    vecs[10] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   0, 64'h0,                    1, C | 64'h3);
    vecs[11] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[12] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[13] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[14] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 0, 1, 1, 0, 8'h00, 14'h30, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[15] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   0, 64'h0,                    1, C | 64'h30);
    vecs[16] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[17] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[18] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 1, 0, 1, 0, 8'h00, 14'h20, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    vecs[19] = mk(1, 0, 8'h00, 14'h20, 64'h0,                   1, 0, 8'h00, 14'h30, 64'h0,                 0, 1, 1, 0, 8'h00, 14'h30, 64'h0,                   1, C | 64'h20,               0, 64'h0);
    // Mixed write contention, then read-after-write from the other port.
    vecs[20] = mk(1, 1, 8'hFF, 14'h20, 64'h1111,                1, 1, 8'h0F, 14'h30, 64'h2222,              1, 0, 1, 1, 8'hFF, 14'h20, 64'h1111,                0, 64'h0,                    1, C | 64'h30);
    vecs[21] = mk(0, 0, 8'h00, 14'h0, 64'h0,                    1, 0, 8'h00, 14'h20, 64'h0,                 0, 1, 1, 0, 8'h00, 14'h20, 64'h0,                   0, 64'h0,                    0, 64'h0);
    vecs[22] = mk(0, 0, 8'h00, 14'h0, 64'h0,                    0, 0, 8'h00, 14'h0, 64'h0,                  0, 0, 0, 0, 8'h00, 14'h20, 64'h0,                   0, 64'h0,                    1, 64'h1111);

    // Reset: outputs at reset values, no grant even with requests pending.
    #1;
    req_valid_0 = 1; req_valid_1 = 1;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk_reset_outputs($sformatf("init_rst%0d", c));
      next_cycle();
    end
    idle_all();
    rst = 1'b0;

    // Table-driven section
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i]);
      #3;
      t = $sformatf("row%0d", i);
      chk({t, " ready0"}, 64'(req_ready_0), 64'(vecs[i].r0));
      chk({t, " ready1"}, 64'(req_ready_1), 64'(vecs[i].r1));
      chk({t, " cs"}, 64'(sram_cs), 64'(vecs[i].cs));
      chk({t, " we"}, 64'(sram_we), 64'(vecs[i].we));
      chk({t, " wem"}, 64'(sram_wem), 64'(vecs[i].wem));
      chk({t, " addr"}, 64'(sram_addr), 64'(vecs[i].addr));
      chk({t, " din"}, sram_din, vecs[i].din);
      chk({t, " rsp_valid0"}, 64'(rsp_valid_0), 64'(vecs[i].rv0));
      chk({t, " rsp_rdata0"}, rsp_rdata_0, vecs[i].rd0);
      chk({t, " rsp_valid1"}, 64'(rsp_valid_1), 64'(vecs[i].rv1));
      chk({t, " rsp_rdata1"}, rsp_rdata_1, vecs[i].rd1);
      next_cycle();
    end

    // Hold-stability: port 1 waits while port 0 holds the grant for 3 cycles.
    p1_acc = 0;
    req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 14'h40;
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 14'h41;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk($sformatf("hold%0d ready0", c), 64'(req_ready_0), 64'd1);
      chk($sformatf("hold%0d ready1", c), 64'(req_ready_1), 64'd0);
      chk($sformatf("hold%0d addr", c), 64'(sram_addr), 64'h40);
      if (req_valid_1 && req_ready_1) p1_acc++;
      next_cycle();
    end
    req_valid_0 = 0;
    #3;
    chk("hold_win ready1", 64'(req_ready_1), 64'd1);
    chk("hold_win addr", 64'(sram_addr), 64'h41);
    chk("hold_win rsp_rdata0", rsp_rdata_0, C | 64'h40);
    if (req_valid_1 && req_ready_1) p1_acc++;
    next_cycle();
    req_valid_1 = 0;
    #3;
    chk("hold_done rsp_valid1", 64'(rsp_valid_1), 64'd1);
    chk("hold_done rsp_rdata1", rsp_rdata_1, C | 64'h41);
    chk("hold_done rsp_valid0", 64'(rsp_valid_0), 64'd0);
    chk("hold p1 accept count", 64'(p1_acc), 64'd1);
    next_cycle();

    // Reset the cycle after a read accept: response is dropped.
    req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 14'h10;
    #3;
    chk("rstrd accept0", 64'(req_ready_0), 64'd1);
    next_cycle();
    rst = 1'b1;
    req_valid_0 = 0;
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 14'h3;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk_reset_outputs($sformatf("rstrd%0d", c));
      next_cycle();
    end
    rst = 1'b0;
    #3;
    chk("post_rst ready1", 64'(req_ready_1), 64'd1);
    chk("post_rst cs", 64'(sram_cs), 64'd1);
    chk("post_rst addr", 64'(sram_addr), 64'h3);
    chk("post_rst rsp_valid0", 64'(rsp_valid_0), 64'd0);
    next_cycle();
    req_valid_1 = 0;
    #3;
    chk("post_rst rsp_valid1", 64'(rsp_valid_1), 64'd1);
    chk("post_rst rsp_rdata1", rsp_rdata_1, C | 64'h3);
    chk("post_rst rsp_valid0 late", 64'(rsp_valid_0), 64'd0);
    next_cycle();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
